// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory, queues
// fetched words in a two-entry buffer toward decode, and handles redirects
// and out-of-range PCs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; PC parked, no fetching
// S_FETCH | fetching one word per cycle while the buffer has room
// S_HALTED| PC out of range or misaligned; fault raised, waiting for redirect
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_SIZE = 64,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic        busy,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   // One past the last valid byte address; 33 bits so a full 4 GiB map still fits.
   localparam logic [32:0] PC_LIMIT = 33'(MEM_SIZE) * 33'd4;
   localparam logic [1:0]  FULL_CNT = 2'(DEPTH);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        fault_q, fault_d;
   logic [31:0] retired_q, retired_d;

   logic [31:0] pc_buf_q    [DEPTH];
   logic [31:0] instr_buf_q [DEPTH];
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  cnt_q, cnt_d;

   logic        push;
   logic        flush;
   logic        handshake;

   function automatic logic pc_ok(input logic [31:0] addr);
      return ({1'b0, addr} < PC_LIMIT) && (addr[1:0] == 2'b00);
   endfunction

   assign imem_addr   = pc_q;
   assign out_valid   = (cnt_q != 2'd0);
   assign out_pc      = pc_buf_q[rd_ptr_q];
   assign out_instr   = instr_buf_q[rd_ptr_q];
   assign handshake   = out_valid & out_ready;
   assign fault       = fault_q;
   assign busy        = (state_q == S_FETCH);
   assign retired_cnt = retired_q;

   // Next state, PC and push decision; a redirect overrides everything else.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      push    = 1'b0;
      flush   = 1'b0;
      if (redirect_valid) begin
         flush = 1'b1;
         pc_d  = redirect_pc;
         if (pc_ok(redirect_pc)) begin
            state_d = S_FETCH;
            fault_d = 1'b0;
         end else begin
            state_d = S_HALTED;
            fault_d = 1'b1;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               if (!pc_ok(pc_q)) begin
                  state_d = S_HALTED;
                  fault_d = 1'b1;
               end else if ((cnt_q != FULL_CNT) || handshake) begin
                  push = 1'b1;
                  pc_d = pc_q + 32'd4;
               end
            end
            S_HALTED: begin
               state_d = S_HALTED;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Buffer pointers and occupancy; a flush empties the buffer outright.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      retired_d = retired_q + {31'd0, handshake};
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (handshake) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, handshake})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         fault_q   <= 1'b0;
         retired_q <= 32'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   // Buffer storage; contents only matter while counted as occupied.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         pc_buf_q[wr_ptr_q]    <= pc_q;
         instr_buf_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule
